// File: rtl/order_inverse_translate_k2_if.sv
// Lane/handshake bundle for order_inverse_translate_k2.
// master: the surrounding logic (drives inputs, consumes outputs).
// slave : the translator block itself.
interface order_inverse_translate_k2_if #(
    parameter int D_WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [D_WIDTH-1:0] ma0_idx;
    logic [D_WIDTH-1:0] bn0_idx;
    logic [D_WIDTH-1:0] ma1_idx;
    logic [D_WIDTH-1:0] bn1_idx;
    logic               agu_done_in;
    logic [D_WIDTH-1:0] l_in;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] order0_out;
    logic [D_WIDTH-1:0] order1_out;
    logic               agu_done_out;
    logic [D_WIDTH-1:0] l_out;
    logic               dec_err;

    modport master (
        output in_valid, ma0_idx, bn0_idx, ma1_idx, bn1_idx, agu_done_in, l_in, out_ready,
        input  in_ready, out_valid, order0_out, order1_out, agu_done_out, l_out, dec_err
    );

    modport slave (
        input  in_valid, ma0_idx, bn0_idx, ma1_idx, bn1_idx, agu_done_in, l_in, out_ready,
        output in_ready, out_valid, order0_out, order1_out, agu_done_out, l_out, dec_err
    );
endinterface

// File: rtl/order_inverse_translate_k2.sv
// order_inverse_translate_k2: rebuilds order indices from (MA, BN) pairs, two lanes per beat.
// order = {MA[DEGREE_WIDTH-DELTA-1:0], (BN - sum of MA digits) mod RADIX}.
// Three-stage valid/ready pipeline; all stages advance together when the output
// slot is free or being consumed, so bubbles travel with the data.
// Optional macro ORDER_INV_RANGE_CHECK_EN adds a sticky out-of-range flag on dec_err.
module order_inverse_translate_k2 #(
    parameter int D_WIDTH      = 16,
    parameter int DEGREE_WIDTH = 16,
    parameter int DELTA        = 4,
    parameter int RADIX        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    order_inverse_translate_k2_if.slave   bus
);
    localparam int          MAW  = DEGREE_WIDTH - DELTA;
    localparam int unsigned NDIG = DEGREE_WIDTH / DELTA - 1;

    // first two MA digits, summed mod RADIX
    function automatic logic [DELTA-1:0] sum_lo(input logic [MAW-1:0] ma);
        logic [DELTA-1:0] acc;
        acc = ma[0 +: DELTA] + ma[DELTA +: DELTA];
        return acc;
    endfunction

    // remaining MA digits folded onto the partial sum, mod RADIX
    function automatic logic [DELTA-1:0] sum_hi(input logic [DELTA-1:0] s01, input logic [MAW-1:0] ma);
        logic [DELTA-1:0] acc;
        acc = s01;
        for (int unsigned k = 2; k < NDIG; k++) begin
            acc = acc + ma[DELTA*k +: DELTA];
        end
        return acc;
    endfunction

    logic adv;

    logic             in_ma_w [2];
    logic [MAW-1:0]   in_ma   [2];
    logic [DELTA-1:0] in_bn   [2];

    // stage 1
    logic             v1;
    logic [MAW-1:0]   ma_1 [2];
    logic [DELTA-1:0] bn_1 [2];
    logic [DELTA-1:0] s_1  [2];
    logic             done_1;
    logic [D_WIDTH-1:0] l_1;

    // stage 2
    logic             v2;
    logic [MAW-1:0]   ma_2 [2];
    logic [DELTA-1:0] bn_2 [2];
    logic [DELTA-1:0] s_2  [2];
    logic             done_2;
    logic [D_WIDTH-1:0] l_2;

    // stage 3 (output)
    logic               v3;
    logic [D_WIDTH-1:0] order_3 [2];
    logic               done_3;
    logic [D_WIDTH-1:0] l_3;

    assign adv          = ~v3 | bus.out_ready;
    assign bus.in_ready = adv;

    // map the two lanes onto arrays, keeping only the fields the decode uses
    always_comb begin
        in_ma[0]   = bus.ma0_idx[MAW-1:0];
        in_ma[1]   = bus.ma1_idx[MAW-1:0];
        in_bn[0]   = bus.bn0_idx[DELTA-1:0];
        in_bn[1]   = bus.bn1_idx[DELTA-1:0];
        in_ma_w[0] = 1'b0;
        in_ma_w[1] = 1'b0;
    end

    // pipeline registers: all stages shift together on adv, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            done_1 <= 1'b0;
            done_2 <= 1'b0;
            done_3 <= 1'b0;
            l_1    <= '0;
            l_2    <= '0;
            l_3    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                ma_1[i]    <= '0;
                bn_1[i]    <= '0;
                s_1[i]     <= '0;
                ma_2[i]    <= '0;
                bn_2[i]    <= '0;
                s_2[i]     <= '0;
                order_3[i] <= '0;
            end
        end else if (adv) begin
            v1     <= bus.in_valid;
            done_1 <= bus.agu_done_in;
            l_1    <= bus.l_in;
            v2     <= v1;
            done_2 <= done_1;
            l_2    <= l_1;
            v3     <= v2;
            done_3 <= done_2;
            l_3    <= l_2;
            for (int unsigned i = 0; i < 2; i++) begin
                ma_1[i]    <= in_ma[i];
                bn_1[i]    <= in_bn[i];
                s_1[i]     <= sum_lo(in_ma[i]);
                ma_2[i]    <= ma_1[i];
                bn_2[i]    <= bn_1[i];
                s_2[i]     <= sum_hi(s_1[i], ma_1[i]);
                order_3[i] <= D_WIDTH'({ma_2[i], DELTA'(bn_2[i] - s_2[i])});
            end
        end
    end

    assign bus.out_valid    = v3;
    assign bus.order0_out   = order_3[0];
    assign bus.order1_out   = order_3[1];
    assign bus.agu_done_out = v3 & done_3;
    assign bus.l_out        = v3 ? l_3 : '0;

`ifdef ORDER_INV_RANGE_CHECK_EN
    logic viol_in;
    logic dec_err_q;

    // any lane field outside its legal range on the incoming pair
    always_comb begin
        viol_in = (bus.bn0_idx >= D_WIDTH'(RADIX)) |
                  (bus.bn1_idx >= D_WIDTH'(RADIX)) |
                  ((bus.ma0_idx >> MAW) != '0) |
                  ((bus.ma1_idx >> MAW) != '0);
    end

    // sticky error: set when an offending pair enters stage 1, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            dec_err_q <= 1'b0;
        end else if (adv && bus.in_valid && viol_in) begin
            dec_err_q <= 1'b1;
        end
    end

    assign bus.dec_err = dec_err_q;

    logic unused_tie;
    assign unused_tie = ^{in_ma_w[0], in_ma_w[1]};
`else
    assign bus.dec_err = 1'b0;

    logic unused_tie;
    assign unused_tie = ^{bus.ma0_idx[D_WIDTH-1:MAW], bus.ma1_idx[D_WIDTH-1:MAW],
                          bus.bn0_idx[D_WIDTH-1:DELTA], bus.bn1_idx[D_WIDTH-1:DELTA],
                          in_ma_w[0], in_ma_w[1], 1'(RADIX)};
`endif

endmodule
